// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC owner and instruction-fetch stage with stall/flush handling for a sync-read imem.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       hazard_ctrl,
    input  logic [1:0]       hazard_reg,
    input  logic [31:0]      branch_target,
    input  logic [31:0]      im_rdata,
    output logic [31:0]      im_addr,
    output logic [31:0]      if_pc,
    output logic [31:0]      if_inst,
    output logic             if_valid,
    output logic             misalign_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam logic [1:0] HC_FLUSH = 2'd1;
    localparam logic [1:0] HC_STALL = 2'd2;

    typedef enum logic [1:0] {BOOT, RUN, STALL, FLUSH} state_t;

    state_t      state, state_nx;
    logic [31:0] pc, pc_d1, inst_hold;
    logic        valid_hold;

    assign im_addr = pc;
    assign if_pc   = pc_d1;

    always_ff @(posedge clk) begin
        if (rst)
            state <= BOOT;
        else
            state <= state_nx;
    end

    // hazard_reg is hazard_ctrl one cycle late, so it lines up with the word now on im_rdata
    always_comb begin
        state_nx = hazard_ctrl == HC_FLUSH ? FLUSH : hazard_ctrl == HC_STALL ? STALL : RUN;
        if_inst  = (state == BOOT || hazard_reg == HC_FLUSH) ? NOP_INST :
                   hazard_reg == HC_STALL ? inst_hold : im_rdata;
        if_valid = (state == BOOT || hazard_reg == HC_FLUSH) ? 1'b0 :
                   hazard_reg == HC_STALL ? valid_hold : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= RESET_PC;
            pc_d1        <= RESET_PC;
            inst_hold    <= NOP_INST;
            valid_hold   <= 1'b0;
            misalign_err <= 1'b0;
            stall_cnt    <= '0;
            flush_cnt    <= '0;
        end else begin
            pc <= hazard_ctrl == HC_FLUSH ? {branch_target[31:2], 2'b00} :
                  hazard_ctrl == HC_STALL ? pc : pc + 32'd4;
            if (hazard_ctrl != HC_STALL)
                pc_d1 <= pc;
            inst_hold  <= if_inst;
            valid_hold <= if_valid;
            if (hazard_ctrl == HC_FLUSH && branch_target[1:0] != 2'b00)
                misalign_err <= 1'b1;
            if (hazard_ctrl == HC_STALL && !(&stall_cnt))
                stall_cnt <= stall_cnt + 1'b1;
            if (hazard_ctrl == HC_FLUSH && !(&flush_cnt))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
endmodule
